batpu_screen_buffer: RTL

Double-buffered 32x32 monochrome pixel store for the BatPU_V2 emulator. It sits directly upstream of the display scan-out stage. It executes CPU screen commands (set X/Y, draw, clear, load, push, clear buffer) against a back buffer. On push it snapshots the back buffer, then moves the snapshot into the front buffer during vertical blanking, so the displayed frame never tears. The front buffer drives the scan-out stage's 32-row x 32-bit pixel buffer input directly.

---
 rtl/screen_pkg.sv | 15 +
 rtl/screen_xfer_fsm.sv | 44 ++++
 rtl/batpu_screen_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// screen_pkg: shared opcodes, geometry and state encodings for the BatPU screen buffer
package screen_pkg;
  localparam int SCR_DIM = 32;
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_X   = 3'd1;
  localparam logic [2:0] OP_SET_Y   = 3'd2;
  localparam logic [2:0] OP_DRAW    = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_LOAD    = 3'd5;
  localparam logic [2:0] OP_PUSH    = 3'd6;
  localparam logic [2:0] OP_CLR_BUF = 3'd7;
  typedef logic [31:0] row_t;
  typedef enum logic {C_IDLE, C_CLR} cmd_state_t;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_COPY} xfer_state_t;
endpackage

// File: rtl/screen_xfer_fsm.sv
// screen_xfer_fsm: waits for a vblank rising edge after a push, then walks rows 0..31 of stage into front
module screen_xfer_fsm
  import screen_pkg::*;
(
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       I_vblank,
  input  logic       I_push,
  output logic       O_wr_en,
  output logic [4:0] O_wr_row,
  output logic       O_pending
);
  xfer_state_t state_q, state_d;
  logic [4:0] row_q, row_d;
  logic vblank_q, vblank_d;
  logic vb_rise;
  always_comb begin
    vblank_d = I_vblank;
    vb_rise  = I_vblank & ~vblank_q;
    state_d  = state_q;
    // a push landing on the vblank edge goes straight to copying the fresh stage
    case (state_q)
      F_IDLE:  state_d = I_push ? (vb_rise ? F_COPY : F_WAIT) : F_IDLE;
      F_WAIT:  state_d = vb_rise ? F_COPY : F_WAIT;
      F_COPY:  state_d = (row_q == 5'd31) ? F_IDLE : F_COPY;
      default: state_d = F_IDLE;
    endcase
    row_d = (state_q == F_COPY) ? row_q + 5'd1 : 5'd0;
  end
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= F_IDLE;
      row_q    <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      vblank_q <= vblank_d;
    end
  end
  assign O_wr_en   = state_q == F_COPY;
  assign O_wr_row  = row_q;
  assign O_pending = state_q != F_IDLE;
endmodule

// File: rtl/batpu_screen_buffer.sv
// batpu_screen_buffer: double-buffered 32x32 mono screen; CPU commands hit back,
// push snapshots into stage, and stage reaches front only during vertical blanking
module batpu_screen_buffer
  import screen_pkg::*;
#(
  parameter bit Y_FLIP = 1'b1
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       I_cmd_valid,
  input  logic [2:0] I_cmd_op,
  input  logic [4:0] I_cmd_data,
  output logic       O_cmd_ready,
  output logic       O_load_data,
  output logic       O_load_valid,
  input  logic       I_vblank,
  output row_t       O_buffer [SCR_DIM],
  output logic       O_swap_pending
);
  cmd_state_t cst_q, cst_d;
  logic [4:0] crow_q, crow_d, x_q, x_d, y_q, y_d;
  row_t back_q [SCR_DIM];
  row_t back_d [SCR_DIM];
  row_t stage_q [SCR_DIM];
  row_t stage_d [SCR_DIM];
  row_t front_q [SCR_DIM];
  row_t front_d [SCR_DIM];
  logic load_valid_q, load_valid_d, load_data_q, load_data_d;
  logic accept, push, xfer_wr;
  logic [4:0] xfer_row, pix_row, pix_bit;
  screen_xfer_fsm u_xfer (
    .I_pxl_clk (I_pxl_clk),
    .I_rst_n   (I_rst_n),
    .I_vblank  (I_vblank),
    .I_push    (push),
    .O_wr_en   (xfer_wr),
    .O_wr_row  (xfer_row),
    .O_pending (O_swap_pending)
  );
  assign O_cmd_ready = (cst_q == C_IDLE) & ~xfer_wr;
  assign accept      = I_cmd_valid & O_cmd_ready;
  assign push        = accept & (I_cmd_op == OP_PUSH);
  // x=0 is the row MSB; with Y_FLIP the CPU's y=0 is the bottom row
  assign pix_row     = Y_FLIP ? ~y_q : y_q;
  assign pix_bit     = ~x_q;
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    back_d       = back_q;
    stage_d      = stage_q;
    front_d      = front_q;
    cst_d        = cst_q;
    crow_d       = crow_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    if (accept) begin
      case (I_cmd_op)
        OP_SET_X:   x_d = I_cmd_data;
        OP_SET_Y:   y_d = I_cmd_data;
        OP_DRAW:    back_d[pix_row][pix_bit] = 1'b1;
        OP_CLEAR:   back_d[pix_row][pix_bit] = 1'b0;
        OP_LOAD: begin
          load_valid_d = 1'b1;
          load_data_d  = back_q[pix_row][pix_bit];
        end
        OP_PUSH:    stage_d = back_q;
        OP_CLR_BUF: begin
          cst_d  = C_CLR;
          crow_d = 5'd0;
        end
        default: ;
      endcase
    end
    if (cst_q == C_CLR) begin
      back_d[crow_q] = '0;
      crow_d         = crow_q + 5'd1;
      cst_d          = (crow_q == 5'd31) ? C_IDLE : C_CLR;
    end
    if (xfer_wr) front_d[xfer_row] = stage_q[xfer_row];
  end
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cst_q        <= C_IDLE;
      crow_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      back_q       <= '{default: '0};
      stage_q      <= '{default: '0};
      front_q      <= '{default: '0};
      load_valid_q <= 1'b0;
      load_data_q  <= 1'b0;
    end else begin
      cst_q        <= cst_d;
      crow_q       <= crow_d;
      x_q          <= x_d;
      y_q          <= y_d;
      back_q       <= back_d;
      stage_q      <= stage_d;
      front_q      <= front_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
    end
  end
  assign O_buffer     = front_q;
  assign O_load_valid = load_valid_q;
  assign O_load_data  = load_data_q;
endmodule
